// File: rtl/key_gen_controller.sv
// Sequencer for the Paillier key-generation datapath: walks the p/q RAMs, launches the core per entry
// and writes each result set back at the same index. Optional watchdog: KEYGEN_CTRL_WATCHDOG_EN.
module key_gen_controller #(
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int FILE_SIZE      = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [RAM_ADDR_WIDTH-1:0] in_rd_addr,
  output logic                      operand_load,
  output logic                      core_start,
  input  logic                      core_done,
  output logic                      out_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0] out_wr_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [RAM_ADDR_WIDTH-1:0] r_idx;
  logic                      w_last;
  logic                      w_accept;
  logic                      w_timeout;

  assign w_last   = (r_idx == RAM_ADDR_WIDTH'(FILE_SIZE - 1));
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef KEYGEN_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_error;

  // The last permitted WAIT cycle is the one where the count equals TIMEOUT_CYCLES-1.
  assign w_timeout = (r_state == S_WAIT) && !core_done &&
                     (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wd_cnt <= '0;
      r_error  <= 1'b0;
    end else begin
      if (r_state == S_LOAD) begin
        r_wd_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
      if (w_accept) begin
        r_error <= 1'b0;
      end else if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign error = r_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES < 1);
  assign w_timeout        = 1'b0;
  assign error            = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_idx <= '0;
      end else if ((r_state == S_WRITE) && !w_last) begin
        r_idx <= r_idx + RAM_ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  w_next = S_LOAD;
      S_LOAD:  w_next = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          w_next = S_WRITE;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_WRITE: w_next = w_last ? S_DONE : S_READ;
      S_DONE:  if (start) w_next = S_READ;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes are masked by reset so an aborting reset never lets a write or launch escape.
  assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done         = (r_state == S_DONE);
  assign operand_load = (r_state == S_LOAD) && !reset;
  assign core_start   = (r_state == S_LOAD) && !reset;
  assign out_wr_en    = (r_state == S_WRITE) && !reset;
  assign in_rd_addr   = r_idx;
  assign out_wr_addr  = r_idx;

endmodule

// File: tb/tb_key_gen_controller.sv
// Bench for key_gen_controller: instance A (FILE_SIZE=10, TIMEOUT_CYCLES=20) and instance B (FILE_SIZE=1),
// each with a core model, an expected write-address queue and a negedge monitor.
`timescale 1ns/1ps
module tb_key_gen_controller;
  localparam int AW = 5;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // instance A
  logic          a_start, a_busy, a_done, a_error, a_operand_load, a_core_start;
  logic          a_core_done, a_out_wr_en, a_model_done, a_spur;
  logic [AW-1:0] a_in_rd_addr, a_out_wr_addr;
  assign a_core_done = a_model_done | a_spur;

  key_gen_controller #(.RAM_ADDR_WIDTH(AW), .FILE_SIZE(10), .TIMEOUT_CYCLES(20)) dut_a (
    .clock(clock), .reset(reset), .start(a_start), .busy(a_busy), .done(a_done),
    .error(a_error), .in_rd_addr(a_in_rd_addr), .operand_load(a_operand_load),
    .core_start(a_core_start), .core_done(a_core_done), .out_wr_en(a_out_wr_en),
    .out_wr_addr(a_out_wr_addr)
  );

  // instance B
  logic          b_start, b_busy, b_done, b_error, b_operand_load, b_core_start;
  logic          b_core_done, b_out_wr_en;
  logic [AW-1:0] b_in_rd_addr, b_out_wr_addr;

  key_gen_controller #(.RAM_ADDR_WIDTH(AW), .FILE_SIZE(1), .TIMEOUT_CYCLES(20)) dut_b (
    .clock(clock), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
    .error(b_error), .in_rd_addr(b_in_rd_addr), .operand_load(b_operand_load),
    .core_start(b_core_start), .core_done(b_core_done), .out_wr_en(b_out_wr_en),
    .out_wr_addr(b_out_wr_addr)
  );

  // core models: core_done arrives lat cycles after core_start; entry a_stall never answers
  int a_lat   = 5;
  int a_stall = -1;
  int a_cnt   = 0;
  always @(posedge clock) begin
    a_model_done <= 1'b0;
    if (reset) begin
      a_cnt <= 0;
    end else if (a_core_start && (int'(a_in_rd_addr) != a_stall)) begin
      if (a_lat == 1) a_model_done <= 1'b1;
      else a_cnt <= a_lat - 1;
    end else if (a_cnt > 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) a_model_done <= 1'b1;
    end
  end

  always @(posedge clock) b_core_done <= !reset && b_core_start;

  // check helper
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard / monitors
  logic [AW-1:0] exp_a[$];
  logic [AW-1:0] exp_b[$];
  int   a_writes = 0, b_writes = 0;
  int   a_rises = 0, b_rises = 0, a_rise_cyc = 0, b_rise_cyc = 0;
  logic a_done_q = 1'b0, b_done_q = 1'b0;

  always @(negedge clock) begin
    if (a_out_wr_en) begin
      a_writes++;
      if (exp_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_wr_unexpected: wrote addr %0d, expected no write", a_out_wr_addr);
      end else begin
        check("a_wr_addr", int'(a_out_wr_addr), int'(exp_a.pop_front()));
      end
    end
    if (a_done && !a_done_q) begin
      a_rises++;
      a_rise_cyc = cyc;
      check("a_busy_at_done", int'(a_busy), 0);
    end
    a_done_q = a_done;
  end

  always @(negedge clock) begin
    if (b_out_wr_en) begin
      b_writes++;
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_wr_unexpected: wrote addr %0d, expected no write", b_out_wr_addr);
      end else begin
        check("b_wr_addr", int'(b_out_wr_addr), int'(exp_b.pop_front()));
      end
    end
    if (b_done && !b_done_q) begin
      b_rises++;
      b_rise_cyc = cyc;
      check("b_busy_at_done", int'(b_busy), 0);
    end
    b_done_q = b_done;
  end

  // driver tasks
  task automatic pulse_a(output int t);
    @(negedge clock);
    a_start = 1'b1;
    t = cyc;
    @(negedge clock);
    a_start = 1'b0;
  endtask

  task automatic pulse_b(output int t);
    @(negedge clock);
    b_start = 1'b1;
    t = cyc;
    @(negedge clock);
    b_start = 1'b0;
  endtask

  task automatic push_a(input int n);
    for (int i = 0; i < n; i++) exp_a.push_back(AW'(i));
  endtask

  task automatic wait_rise(input bit sel_b, input int budget, output int rc);
    int  r0;
    bit  ok;
    r0 = sel_b ? b_rises : a_rises;
    ok = 1'b0;
    rc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #1;
      if ((sel_b ? b_rises : a_rises) != r0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      rc = sel_b ? b_rise_cyc : a_rise_cyc;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_wait: done not seen within %0d cycles", sel_b ? "b" : "a", budget);
    end
  endtask

  initial begin
    int  t, rc, w0, busy_cnt;
    bit  ok, err_seen;
    reset   = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    a_spur  = 1'b0;
    repeat (3) @(negedge clock);

    // reset state
    check("rst_busy", int'(a_busy), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_error", int'(a_error), 0);
    check("rst_in_rd_addr", int'(a_in_rd_addr), 0);
    check("rst_out_wr_addr", int'(a_out_wr_addr), 0);
    check("rst_out_wr_en", int'(a_out_wr_en), 0);
    check("rst_operand_load", int'(a_operand_load), 0);
    check("rst_core_start", int'(a_core_start), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // basic run: L=5, 10 entries, run length 1 + 10*(5+3) = 81
    w0 = a_writes;
    push_a(10);
    pulse_a(t);
    wait_rise(1'b0, 300, rc);
    check("t1_run_len", rc - t, 81);
    check("t1_writes", a_writes - w0, 10);
    check("t1_queue_left", exp_a.size(), 0);
    check("t1_error", int'(a_error), 0);

    // restart from DONE with ignored starts and a spurious core_done in READ
    w0 = a_writes;
    push_a(10);
    pulse_a(t);
    check("t2_done_cleared", int'(a_done), 0);
    repeat (20) @(negedge clock);
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (a_out_wr_en) begin
        ok = 1'b1;
        break;
      end
    end
    check("t2_write_seen", int'(ok), 1);
    @(posedge clock);
    #1 a_spur = 1'b1;
    @(posedge clock);
    #1 a_spur = 1'b0;
    repeat (7) @(negedge clock);
    a_start = 1'b1;
    @(negedge clock);
    a_start = 1'b0;
    wait_rise(1'b0, 300, rc);
    check("t2_run_len", rc - t, 81);
    check("t2_writes", a_writes - w0, 10);

    // reset while in WAIT at idx 4
    w0 = a_writes;
    push_a(4);
    pulse_a(t);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (a_core_start && (a_in_rd_addr == AW'(4))) begin
        ok = 1'b1;
        break;
      end
    end
    check("t3_reached_idx4", int'(ok), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("t3_busy", int'(a_busy), 0);
    check("t3_done", int'(a_done), 0);
    check("t3_out_wr_en", int'(a_out_wr_en), 0);
    check("t3_in_rd_addr", int'(a_in_rd_addr), 0);
    check("t3_core_start", int'(a_core_start), 0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("t3_writes_before_reset", a_writes - w0, 4);
    check("t3_idle_busy", int'(a_busy), 0);
    w0 = a_writes;
    push_a(10);
    pulse_a(t);
    wait_rise(1'b0, 300, rc);
    check("t3_rerun_len", rc - t, 81);
    check("t3_rerun_writes", a_writes - w0, 10);

    // core stalls at idx 2
    a_stall = 2;
    exp_a.push_back(AW'(0));
    exp_a.push_back(AW'(1));
    w0 = a_writes;
`ifdef KEYGEN_CTRL_WATCHDOG_EN
    pulse_a(t);
    wait_rise(1'b0, 300, rc);
    check("wd_writes", a_writes - w0, 2);
    check("wd_done", int'(a_done), 1);
    check("wd_error", int'(a_error), 1);
    repeat (10) @(negedge clock);
    check("wd_done_held", int'(a_done), 1);
    check("wd_error_held", int'(a_error), 1);
    a_stall = -1;
    push_a(10);
    pulse_a(t);
    check("wd_done_cleared", int'(a_done), 0);
    check("wd_error_cleared", int'(a_error), 0);
    wait_rise(1'b0, 300, rc);
    check("wd_rerun_len", rc - t, 81);
    check("wd_rerun_error", int'(a_error), 0);
`else
    pulse_a(t);
    busy_cnt = 0;
    err_seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clock);
      if (a_busy) busy_cnt++;
      if (a_error) err_seen = 1'b1;
    end
    check("stall_busy_cycles", busy_cnt, 1100);
    check("stall_error", int'(err_seen), 0);
    check("stall_writes", a_writes - w0, 2);
    a_stall = -1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("stall_recover_busy", int'(a_busy), 0);
`endif

    // FILE_SIZE=1, L=1: run length 1 + 1*(1+3) = 5
    exp_b.push_back(AW'(0));
    pulse_b(t);
    wait_rise(1'b1, 50, rc);
    check("b_run_len", rc - t, 5);
    check("b_writes", b_writes, 1);
    exp_b.push_back(AW'(0));
    pulse_b(t);
    check("b_done_cleared", int'(b_done), 0);
    wait_rise(1'b1, 50, rc);
    check("b_rerun_len", rc - t, 5);
    check("b_rerun_writes", b_writes, 2);
    check("b_error", int'(b_error), 0);

    repeat (5) @(negedge clock);
    check("a_queue_final", exp_a.size(), 0);
    check("b_queue_final", exp_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_gen_controller.md
# key_gen_controller

Sequencer for the Paillier key-generation datapath. On `start` it walks entries 0..FILE_SIZE-1 of the p and q input RAMs, launches the key-generation compute core once per entry, and writes each result set (n, lambda, g, u) into the output RAMs at the same index. It sits inside `key_generation_top` between the input RAMs, the compute core, and the output RAMs, and raises `done` when every entry has been written.

## Interface
Parameters:
- `RAM_ADDR_WIDTH`, default 5: address width of the p, q and output RAMs.
- `FILE_SIZE`, default 10: number of entries processed per run; legal range 1..2^RAM_ADDR_WIDTH.
- `TIMEOUT_CYCLES`, default 65535: watchdog limit in cycles, used only when the watchdog is compiled in; legal range ≥1.

Ports:
- `clock`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: run request, sampled only in IDLE or DONE.
- `busy`  out  1: high in every state except IDLE and DONE.
- `done`  out  1: high in DONE; held until the next accepted `start` or `reset`.
- `error`  out  1: watchdog fired in this run; valid while `done`=1.
- `in_rd_addr`  out  RAM_ADDR_WIDTH: read address to both the p and q RAMs; read latency is 1 cycle.
- `operand_load`  out  1: 1-cycle pulse; core latches p/q RAM data this cycle.
- `core_start`  out  1: 1-cycle pulse, coincident with `operand_load`.
- `core_done`  in  1: 1-cycle pulse from the core when its results are valid.
- `out_wr_en`  out  1: 1-cycle write strobe to all four output RAMs.
- `out_wr_addr`  out  RAM_ADDR_WIDTH: output RAM write address.

## Operation
- States: IDLE, READ, LOAD, WAIT, WRITE, DONE.
- Internal index `idx`, width RAM_ADDR_WIDTH, reset value 0.
- IDLE: when `start`=1, set idx to 0 and go to READ.
- READ: drive `in_rd_addr`=idx, then go to LOAD.
- LOAD: RAM data is valid this cycle. Assert `operand_load`=1 and `core_start`=1, then go to WAIT.
- WAIT: hold until `core_done`=1, then go to WRITE.
- WRITE: drive `out_wr_en`=1 and `out_wr_addr`=idx.
  - If idx==FILE_SIZE-1, go to DONE.
  - Otherwise increment idx and go to READ.
- DONE: `done`=1. When `start`=1, clear `done` and `error`, set idx to 0, and go to READ.
- `in_rd_addr` holds idx in every state. `out_wr_addr` holds idx; it is meaningful only while `out_wr_en`=1.
- `start` outside IDLE/DONE is ignored.
- `core_done` outside WAIT is ignored and has no side effects.
- `core_done` in the same cycle as `core_start` (LOAD) is ignored; the core's earliest legal `core_done` is the cycle after LOAD.
- idx never wraps. The comparison uses FILE_SIZE-1, so FILE_SIZE=2^RAM_ADDR_WIDTH ends at the all-ones address.

## Timing
- Reset (synchronous): state IDLE; idx 0. All outputs 0: `busy`, `done`, `error`, `operand_load`, `core_start`, `out_wr_en`, `in_rd_addr`, `out_wr_addr`.
- `reset` mid-run aborts the run immediately. No `out_wr_en` is issued in the reset cycle or after it.
- Per-entry timing, with core latency L ≥ 1 cycles from `core_start` to `core_done`: READ 1 + LOAD 1 + WAIT L + WRITE 1 = L+3 cycles.
- Run length from the `start` sampling edge to `done` rising: 1 + FILE_SIZE·(L+3) cycles.
- `busy` rises the cycle after `start` is sampled and falls in the same cycle `done` rises.

## Configuration
- Macro `KEYGEN_CTRL_WATCHDOG_EN`.
- Defined:
  - A cycle counter clears on entry to WAIT and counts while in WAIT.
  - If it reaches TIMEOUT_CYCLES without `core_done`, go directly to DONE with `error`=1 and no write for that entry.
  - `error` clears on the next accepted `start` or on `reset`.
- Undefined:
  - No counter is built, `error` is tied to 0, and WAIT waits indefinitely.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Reset, then pulse `start` with a core model of L=5 and FILE_SIZE=10. Expect:
  - `out_wr_en` exactly 10 times, at addresses 0..9 in order.
  - `done` rises 81 cycles after `start` is sampled.
  - `busy` falls in the same cycle `done` rises.
- Pulse `start` twice during a run, and inject a spurious `core_done` in READ. Expect no change to the sequence: still 10 writes, same `done` cycle.
- Assert `reset` for 1 cycle while in WAIT at idx=4. Expect all outputs 0 the next cycle and no further writes. A new `start` then processes addresses 0..9.
- With FILE_SIZE=1 and L=1, expect one write at address 0 and `done` 5 cycles after `start`. Pulse `start` in DONE: `done` clears the next cycle and a second run completes.
- With `KEYGEN_CTRL_WATCHDOG_EN` defined and TIMEOUT_CYCLES=20, have the core never respond at idx=2. Expect:
  - Writes at addresses 0 and 1 only.
  - `done`=1 and `error`=1, held until the next `start`.
- Without the macro, use the same stalled core. Expect `busy` held high for at least 1000 cycles and `error`=0 throughout.
